// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and state type for the instruction fetch stage.
//   PC_RESET_DEFAULT - default PC after reset
//   INST_BYTES       - bytes per instruction word (PC increment)
//   fetch_state_t    - fetch FSM states
package fetch_pkg;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
   localparam int unsigned INST_BYTES = 4;
   typedef enum logic [1:0] {RESET, RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: in-order buffer of fetched {pc, inst} words.
//   clk, resetn       - clock, synchronous active-low reset
//   push, wdata       - write one entry
//   pop, rdata        - head entry, removed on pop
//   flush             - empty the buffer (wins over push/pop)
//   count             - entries held
module inst_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [63:0]            wdata,
   output logic [63:0]            rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [63:0]   mem_q [DEPTH];
   logic [63:0]   mem_d [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wp_q] = wdata;
      wp_d = flush ? '0 : wp_q + AW'(push);
      rp_d = flush ? '0 : rp_q + AW'(pop);
      cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      rdata = mem_q[rp_q];
      count = cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_q <= '{default: '0};
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, instruction-memory request/response handling and decoder handoff.
//   clk, resetn                      - clock, synchronous active-low reset
//   imem_req/addr/gnt/rvalid/rdata   - instruction memory read handshake
//   inst_valid/inst/inst_pc/ready    - word handed to the decoder
//   jmp, jmp_target                  - redirect, qualified by the transfer
module inst_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        jmp,
   input  logic [31:0] jmp_target
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [31:0] STEP = 32'(INST_BYTES);
   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt;
   logic [CW-1:0] pend_q, pend_d, drop_q, drop_d, cnt;
   logic          gnt, pop, redir, push;
   logic [63:0]   head;
   inst_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .flush  (redir),
      .wdata  ({resp_pc_q, imem_rdata}),
      .rdata  (head),
      .count  (cnt)
   );
   always_comb begin
      // pend counts reserved FIFO slots, so a granted word always has room
      imem_req = state_q == RUN && pend_q + cnt < CW'(DEPTH);
      imem_addr = fetch_pc_q;
      inst_valid = cnt != '0 && state_q == RUN;
      inst_pc = head[63:32];
      inst = head[31:0];
      gnt = imem_req & imem_gnt;
      pop = inst_valid & inst_ready;
      redir = pop & jmp;
      // a response landing in the redirect cycle is wrong-path
      push = imem_rvalid && drop_q == '0 && !redir;
      tgt = jmp_target & ~32'h3;
      pend_d = pend_q + CW'(gnt) - CW'(imem_rvalid);
      drop_d = redir ? pend_d : drop_q - CW'(imem_rvalid && drop_q != '0);
      fetch_pc_d = redir ? tgt : fetch_pc_q + (gnt ? STEP : '0);
      resp_pc_d = redir ? tgt : resp_pc_q + (push ? STEP : '0);
      state_d = state_q == RESET ? RUN :
                state_q == RUN   ? (redir && pend_d != '0 ? FLUSH : RUN) :
                                   (drop_d == '0 ? RUN : FLUSH);
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= RESET;
         fetch_pc_q <= PC_RESET;
         resp_pc_q <= PC_RESET;
         pend_q <= '0;
         drop_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q <= resp_pc_d;
         pend_q <= pend_d;
         drop_q <= drop_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch against hand-computed values.
module tb_inst_fetch;
   logic        clk, resetn, imem_gnt, imem_rvalid, inst_ready, jmp, hold;
   logic [31:0] imem_rdata, jmp_target;
   logic        imem_req, inst_valid, w_req, w_valid;
   logic [31:0] imem_addr, inst, inst_pc, w_addr, w_inst, w_pc;
   logic [31:0] g_log[$], t_pc[$], t_inst[$], w_log[$], mq[$];
   int          checks = 0, errors = 0;

   inst_fetch #(.PC_RESET(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready), .jmp(jmp), .jmp_target(jmp_target)
   );

   // second instance with no memory responses: exercises PC wrap and the full limit
   inst_fetch #(.PC_RESET(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
      .clk(clk), .resetn(resetn), .imem_req(w_req), .imem_addr(w_addr),
      .imem_gnt(1'b1), .imem_rvalid(1'b0), .imem_rdata(32'h0),
      .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
      .inst_ready(1'b1), .jmp(1'b0), .jmp_target(32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a == 32'h0 ? 32'h0043_0820 : {~a[15:0], a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // in-order memory: grant at edge N, earliest response in cycle N+1; hold stalls responses
   always @(posedge clk) begin
      if (!resetn) begin
         mq.delete();
         imem_rvalid <= 1'b0;
         imem_rdata <= '0;
      end else begin
         if (imem_rvalid) void'(mq.pop_front());
         if (imem_req && imem_gnt) mq.push_back(imem_addr);
         imem_rvalid <= !hold && mq.size() != 0;
         imem_rdata <= mq.size() != 0 ? mem_word(mq[0]) : 32'h0;
      end
   end

   always @(posedge clk) begin
      if (imem_req && imem_gnt) g_log.push_back(imem_addr);
      if (inst_valid && inst_ready) begin
         t_pc.push_back(inst_pc);
         t_inst.push_back(inst);
      end
      if (w_req) w_log.push_back(w_addr);
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int    n, ng;
      logic  found;
      logic [31:0] jpc;
      resetn = 1'b0;
      imem_gnt = 1'b1;
      inst_ready = 1'b1;
      jmp = 1'b0;
      jmp_target = 32'h0;
      hold = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_waddr", w_addr, 32'hFFFF_FFF8);
      // stream, then stall the decoder on the first word
      resetn = 1'b1;
      @(negedge clk);
      chk("c1_req", imem_req, 1);
      chk("c1_addr", imem_addr, 0);
      chk("c1_valid", inst_valid, 0);
      @(negedge clk);
      chk("c2_valid", inst_valid, 0);
      chk("c2_addr", imem_addr, 4);
      @(negedge clk);
      chk("c3_valid", inst_valid, 1);
      chk("c3_pc", inst_pc, 0);
      chk("c3_inst", inst, 32'h0043_0820);
      inst_ready = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_req", imem_req, 0);
      chk("stall_inst", inst, 32'h0043_0820);
      chk("stall_pc", inst_pc, 0);
      chk("stall_grants", g_log.size(), 2);
      chk("wrap_n", w_log.size(), 4);
      chk("wrap0", w_log[0], 32'hFFFF_FFF8);
      chk("wrap1", w_log[1], 32'hFFFF_FFFC);
      chk("wrap2", w_log[2], 32'h0000_0000);
      chk("wrap3", w_log[3], 32'h0000_0004);
      chk("wrap_full", w_req, 0);
      inst_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("res_pc0", t_pc[0], 0);
      chk("res_pc1", t_pc[1], 4);
      chk("res_pc2", t_pc[2], 8);
      chk("res_inst1", t_inst[1], mem_word(4));
      chk("res_g2", g_log[2], 8);
      chk("res_g3", g_log[3], 12);
      // jump on pc 4 with a request granted in the jump cycle and held by memory
      resetn = 1'b0;
      inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      g_log.delete();
      t_pc.delete();
      t_inst.delete();
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      hold = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      chk("j_pc", inst_pc, 4);
      chk("j_req", imem_req, 1);
      chk("j_addr", imem_addr, 8);
      jmp = 1'b1;
      jmp_target = 32'h103;
      @(negedge clk);
      jmp = 1'b0;
      chk("fl_valid", inst_valid, 0);
      chk("fl_req", imem_req, 0);
      chk("fl_addr", imem_addr, 32'h100);
      repeat (2) @(negedge clk);
      chk("fl_hold_req", imem_req, 0);
      hold = 1'b0;
      @(negedge clk);
      chk("fl_rsp_req", imem_req, 0);
      @(negedge clk);
      chk("fl_done_req", imem_req, 1);
      chk("fl_done_addr", imem_addr, 32'h100);
      repeat (6) @(negedge clk);
      chk("j_t1", t_pc[1], 4);
      chk("j_t2", t_pc[2], 32'h100);
      chk("j_t2_inst", t_inst[2], mem_word(32'h100));
      chk("j_g3", g_log[3], 32'h100);
      // redirect in the same cycle as a response
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = inst_valid && imem_rvalid;
      end
      chk("same_find", found, 1);
      n = t_pc.size();
      ng = g_log.size();
      jpc = inst_pc;
      jmp = 1'b1;
      jmp_target = 32'h200;
      @(negedge clk);
      jmp = 1'b0;
      repeat (6) @(negedge clk);
      chk("same_jword", t_pc[n], jpc);
      chk("same_next", t_pc[n + 1], 32'h200);
      chk("same_inst", t_inst[n + 1], mem_word(32'h200));
      chk("same_grant", g_log[ng], 32'h200);
      // reset with two requests outstanding
      hold = 1'b1;
      repeat (6) @(negedge clk);
      chk("pend2_req", imem_req, 0);
      chk("pend2_valid", inst_valid, 0);
      resetn = 1'b0;
      @(negedge clk);
      chk("mid_valid", inst_valid, 0);
      chk("mid_req", imem_req, 0);
      chk("mid_addr", imem_addr, 0);
      hold = 1'b0;
      g_log.delete();
      t_pc.delete();
      t_inst.delete();
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      chk("rs_g0", g_log[0], 0);
      chk("rs_t0", t_pc[0], 0);
      chk("rs_i0", t_inst[0], 32'h0043_0820);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
